// File: rtl/tdm_demux1t2.sv
// TDM receiver: steers a tagged sample stream onto lanes A/B, pairs A-then-B
// samples, and reports ordering errors and B-side timeouts with a saturating count.
module tdm_demux1t2 #(
  parameter int W       = 1,
  parameter int TIMEOUT = 16,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  din,
  input  logic          sel,
  input  logic          din_valid,
  output logic [W-1:0]  oa,
  output logic [W-1:0]  ob,
  output logic          oa_stb,
  output logic          ob_stb,
  output logic [W-1:0]  pa,
  output logic [W-1:0]  pb,
  output logic          pair_valid,
  output logic          seq_err,
  output logic          timeout,
  output logic [CW-1:0] err_cnt
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic {
    S_EXPECT_A = 1'b0,
    S_EXPECT_B = 1'b1
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [W-1:0]  r_pend_a;

  logic w_lane_a;
  logic w_lane_b;
  logic w_seq_err;
  logic w_timeout;
  logic w_cnt_sat;

  assign w_lane_a  = din_valid & ~sel;
  assign w_lane_b  = din_valid & sel;
  assign w_cnt_sat = &err_cnt;

  // Classify this cycle's event against the expected A-then-B order.
  always_comb begin
    w_seq_err = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_EXPECT_A: begin
        w_seq_err = w_lane_b;
      end
      S_EXPECT_B: begin
        w_seq_err = w_lane_a;
        if (!din_valid && (r_timer == TMAX)) begin
          w_timeout = 1'b1;
        end else begin
          w_timeout = 1'b0;
        end
      end
      default: begin
        w_seq_err = 1'b0;
        w_timeout = 1'b0;
      end
    endcase
  end

  // Lane registers, pairing FSM, strobes and error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_EXPECT_A;
      r_timer    <= {TW{1'b0}};
      r_pend_a   <= {W{1'b0}};
      oa         <= {W{1'b0}};
      ob         <= {W{1'b0}};
      pa         <= {W{1'b0}};
      pb         <= {W{1'b0}};
      oa_stb     <= 1'b0;
      ob_stb     <= 1'b0;
      pair_valid <= 1'b0;
      seq_err    <= 1'b0;
      timeout    <= 1'b0;
      err_cnt    <= {CW{1'b0}};
    end else begin
      oa_stb     <= w_lane_a;
      ob_stb     <= w_lane_b;
      pair_valid <= 1'b0;
      seq_err    <= w_seq_err;
      timeout    <= w_timeout;

      if (w_lane_a) begin
        oa <= din;
      end
      if (w_lane_b) begin
        ob <= din;
      end

      // seq_err and timeout are mutually exclusive, so at most +1 per cycle.
      if ((w_seq_err || w_timeout) && !w_cnt_sat) begin
        err_cnt <= err_cnt + CW'(1);
      end

      case (r_state)
        S_EXPECT_A: begin
          r_timer <= {TW{1'b0}};
          if (w_lane_a) begin
            r_pend_a <= din;
            r_state  <= S_EXPECT_B;
          end else begin
            r_state  <= S_EXPECT_A;
          end
        end
        S_EXPECT_B: begin
          if (w_lane_b) begin
            pa         <= r_pend_a;
            pb         <= din;
            pair_valid <= 1'b1;
            r_timer    <= {TW{1'b0}};
            r_state    <= S_EXPECT_A;
          end else if (w_lane_a) begin
            r_pend_a <= din;
            r_timer  <= {TW{1'b0}};
            r_state  <= S_EXPECT_B;
          end else if (w_timeout) begin
            r_timer <= {TW{1'b0}};
            r_state <= S_EXPECT_A;
          end else begin
            r_timer <= r_timer + TW'(1);
            r_state <= S_EXPECT_B;
          end
        end
        default: begin
          r_timer <= {TW{1'b0}};
          r_state <= S_EXPECT_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demux1t2.sv
// Directed self-checking bench for tdm_demux1t2: a default instance (CW=8)
// and a CW=2 instance share stimulus; tasks run in sequence from one initial block.
module tb_tdm_demux1t2;

  logic       clk;
  logic       rst;
  logic [0:0] din;
  logic       sel;
  logic       din_valid;

  logic [0:0] oa, ob, pa, pb;
  logic       oa_stb, ob_stb, pair_valid, seq_err, timeout;
  logic [7:0] err_cnt;

  logic [0:0] oa2, ob2, pa2, pb2;
  logic       oa_stb2, ob_stb2, pair_valid2, seq_err2, timeout2;
  logic [1:0] err_cnt2;

  int n_checks;
  int n_errors;

  typedef struct packed {
    logic       v;
    logic       s;
    logic       d;
    logic [3:0] data;   // {oa, ob, pa, pb}
    logic [4:0] flags;  // {oa_stb, ob_stb, pair_valid, seq_err, timeout}
    logic [7:0] err;
  } row_t;

  tdm_demux1t2 #(.W(1), .TIMEOUT(16), .CW(8)) u_dut (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .din_valid(din_valid),
    .oa(oa), .ob(ob), .oa_stb(oa_stb), .ob_stb(ob_stb), .pa(pa), .pb(pb),
    .pair_valid(pair_valid), .seq_err(seq_err), .timeout(timeout), .err_cnt(err_cnt)
  );

  tdm_demux1t2 #(.W(1), .TIMEOUT(16), .CW(2)) u_dut2 (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .din_valid(din_valid),
    .oa(oa2), .ob(ob2), .oa_stb(oa_stb2), .ob_stb(ob_stb2), .pa(pa2), .pb(pb2),
    .pair_valid(pair_valid2), .seq_err(seq_err2), .timeout(timeout2), .err_cnt(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input logic v, input logic s, input logic d);
    @(negedge clk);
    din_valid = v;
    sel       = s;
    din       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #7;
    n_checks++;
    if ({oa, ob, pa, pb, oa_stb, ob_stb, pair_valid, seq_err, timeout, err_cnt} !== 17'b0) begin
      n_errors++;
      $display("FAIL reset_state got %b required all zero",
               {oa, ob, pa, pb, oa_stb, ob_stb, pair_valid, seq_err, timeout, err_cnt});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      n_checks++;
      if ({oa, ob, pa, pb, oa_stb, ob_stb, pair_valid, seq_err, timeout, err_cnt} !== 17'b0) begin
        n_errors++;
        $display("FAIL reset_idle[%0d] got %b required all zero", i,
                 {oa, ob, pa, pb, oa_stb, ob_stb, pair_valid, seq_err, timeout, err_cnt});
      end
    end
  endtask

  task automatic run_rows(input string name, input row_t tbl [], input int n);
    for (int i = 0; i < n; i++) begin
      cyc(tbl[i].v, tbl[i].s, tbl[i].d);
      n_checks++;
      if ({oa, ob, pa, pb, oa_stb, ob_stb, pair_valid, seq_err, timeout, err_cnt} !==
          {tbl[i].data, tbl[i].flags, tbl[i].err}) begin
        n_errors++;
        $display("FAIL %s[%0d] got data=%b flags=%b err=%0d required data=%b flags=%b err=%0d",
                 name, i, {oa, ob, pa, pb}, {oa_stb, ob_stb, pair_valid, seq_err, timeout},
                 err_cnt, tbl[i].data, tbl[i].flags, tbl[i].err);
      end
    end
  endtask

  task automatic test_pair();
    row_t t [];
    t = new[3];
    t[0] = '{1'b1, 1'b0, 1'b1, 4'b1000, 5'b10000, 8'd0};
    t[1] = '{1'b1, 1'b1, 1'b0, 4'b1010, 5'b01100, 8'd0};
    t[2] = '{1'b0, 1'b0, 1'b0, 4'b1010, 5'b00000, 8'd0};
    run_rows("pair", t, 3);
  endtask

  task automatic test_b_first();
    row_t t [];
    t = new[3];
    t[0] = '{1'b1, 1'b1, 1'b1, 4'b1110, 5'b01010, 8'd1};
    t[1] = '{1'b1, 1'b0, 1'b1, 4'b1110, 5'b10000, 8'd1};
    t[2] = '{1'b1, 1'b1, 1'b1, 4'b1111, 5'b01100, 8'd1};
    run_rows("b_first", t, 3);
  endtask

  task automatic test_replace_a();
    row_t t [];
    t = new[3];
    t[0] = '{1'b1, 1'b0, 1'b1, 4'b1111, 5'b10000, 8'd1};
    t[1] = '{1'b1, 1'b0, 1'b0, 4'b0111, 5'b10010, 8'd2};
    t[2] = '{1'b1, 1'b1, 1'b1, 4'b0101, 5'b01100, 8'd2};
    run_rows("replace_a", t, 3);
  endtask

  task automatic test_timeout();
    row_t t [];
    // A sample, 15 quiet cycles, timeout on the 16th, one quiet cycle, late B.
    t = new[19];
    t[0] = '{1'b1, 1'b0, 1'b1, 4'b1101, 5'b10000, 8'd2};
    for (int i = 1; i <= 15; i++) t[i] = '{1'b0, 1'b0, 1'b0, 4'b1101, 5'b00000, 8'd2};
    t[16] = '{1'b0, 1'b0, 1'b0, 4'b1101, 5'b00001, 8'd3};
    t[17] = '{1'b0, 1'b0, 1'b0, 4'b1101, 5'b00000, 8'd3};
    t[18] = '{1'b1, 1'b1, 1'b0, 4'b1001, 5'b01010, 8'd4};
    run_rows("timeout", t, 19);
    // B lands exactly on the expiry cycle: pair wins, no timeout.
    t = new[18];
    t[0] = '{1'b1, 1'b0, 1'b0, 4'b0001, 5'b10000, 8'd4};
    for (int i = 1; i <= 15; i++) t[i] = '{1'b0, 1'b0, 1'b0, 4'b0001, 5'b00000, 8'd4};
    t[16] = '{1'b1, 1'b1, 1'b1, 4'b0101, 5'b01100, 8'd4};
    t[17] = '{1'b0, 1'b0, 1'b0, 4'b0101, 5'b00000, 8'd4};
    run_rows("expiry_b", t, 18);
  endtask

  task automatic test_back_to_back();
    row_t t [];
    t = new[5];
    t[0] = '{1'b1, 1'b0, 1'b1, 4'b1101, 5'b10000, 8'd4};
    t[1] = '{1'b1, 1'b1, 1'b0, 4'b1010, 5'b01100, 8'd4};
    t[2] = '{1'b1, 1'b0, 1'b0, 4'b0010, 5'b10000, 8'd4};
    t[3] = '{1'b1, 1'b1, 1'b1, 4'b0101, 5'b01100, 8'd4};
    t[4] = '{1'b0, 1'b0, 1'b0, 4'b0101, 5'b00000, 8'd4};
    run_rows("back_to_back", t, 5);
  endtask

  task automatic test_saturate_and_reset();
    logic [1:0] exp2 [5];
    exp2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    @(negedge clk);
    rst = 1'b1;
    din_valid = 1'b0;
    #1;
    n_checks++;
    if ({err_cnt, err_cnt2, pa, pb} !== 12'b0) begin
      n_errors++;
      $display("FAIL async_reset got err=%0d err2=%0d pa=%b pb=%b required 0", err_cnt, err_cnt2, pa, pb);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      n_checks++;
      if (err_cnt2 !== exp2[i] || err_cnt !== 8'(i + 1) || seq_err2 !== 1'b1) begin
        n_errors++;
        $display("FAIL saturate[%0d] got err2=%0d err=%0d seq_err2=%b required err2=%0d err=%0d seq_err2=1",
                 i, err_cnt2, err_cnt, seq_err2, exp2[i], i + 1);
      end
    end
    cyc(1'b1, 1'b0, 1'b1);
    n_checks++;
    if (oa_stb !== 1'b1 || oa !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_pair_a got oa=%b oa_stb=%b required oa=1 oa_stb=1", oa, oa_stb);
    end
    @(negedge clk);
    rst = 1'b1;
    din_valid = 1'b1;
    sel = 1'b1;
    din = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({pair_valid, pair_valid2, err_cnt, err_cnt2, oa, ob} !== 14'b0) begin
      n_errors++;
      $display("FAIL reset_mid_pair got pv=%b pv2=%b err=%0d err2=%0d oa=%b ob=%b required 0",
               pair_valid, pair_valid2, err_cnt, err_cnt2, oa, ob);
    end
    @(negedge clk);
    rst = 1'b0;
    din_valid = 1'b0;
    // Pending A was discarded, so a B now is an ordering error, not a pair.
    cyc(1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({pair_valid, seq_err, err_cnt, pa, pb} !== {1'b0, 1'b1, 8'd1, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL after_reset_b got pv=%b seq_err=%b err=%0d pa=%b pb=%b required pv=0 seq_err=1 err=1 pa=0 pb=0",
               pair_valid, seq_err, err_cnt, pa, pb);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    din       = 1'b0;
    sel       = 1'b0;
    din_valid = 1'b0;
    test_reset();
    test_pair();
    test_b_first();
    test_replace_a();
    test_timeout();
    test_back_to_back();
    test_saturate_and_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux1t2.md
Name: tdm_demux1t2

Overview:
- Receiving end of the 2:1 selector path: takes a time-multiplexed stream (din tagged by sel) and steers each sample to lane A (sel=0) or lane B (sel=1), holding each lane's last value.
- Tracks the expected A-then-B ordering, emits a registered A/B pair strobe, and flags sequence errors and timeouts.
- Sits downstream of mux2t1 wherever two sources share one link.

Parameters:
- W, 1, data width of din/oa/ob/pa/pb.
- TIMEOUT, 16, max cycles allowed in EXPECT_B without a valid sample before abort (>=2).
- CW, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- din  input  W  multiplexed sample.
- sel  input  1  lane tag: 0 = A, 1 = B.
- din_valid  input  1  din/sel qualified this cycle.
- oa  output  W  last lane-A sample, held.
- ob  output  W  last lane-B sample, held.
- oa_stb  output  1  1-cycle pulse: oa updated.
- ob_stb  output  1  1-cycle pulse: ob updated.
- pa  output  W  A half of the last complete pair.
- pb  output  W  B half of the last complete pair.
- pair_valid  output  1  1-cycle pulse: pa/pb updated.
- seq_err  output  1  1-cycle pulse: out-of-order tag.
- timeout  output  1  1-cycle pulse: EXPECT_B aborted.
- err_cnt  output  CW  saturating count of seq_err plus timeout events.

Behaviour:
- Reset, asynchronous and immediate:
  - oa, ob, pa, pb, err_cnt = 0.
  - All strobes = 0.
  - State = EXPECT_A; timer = 0.
- All outputs are registered. A valid sample at edge k updates outputs and strobes visible after edge k, so latency is 1 cycle. Strobes last exactly one cycle.
- Lane steering is independent of state: any valid sel=0 loads oa and pulses oa_stb; any valid sel=1 loads ob and pulses ob_stb. din_valid=0 loads nothing.
- FSM:
  - EXPECT_A, valid sel=0: latch the sample as pending A; go to EXPECT_B; timer = 0.
  - EXPECT_A, valid sel=1: seq_err; stay in EXPECT_A; no pair.
  - EXPECT_B, valid sel=1: pa = pending A, pb = din; pair_valid; go to EXPECT_A.
  - EXPECT_B, valid sel=0: seq_err; pending A replaced by the new sample; stay in EXPECT_B; timer = 0.
  - EXPECT_B, no valid: timer increments. When timer reaches TIMEOUT-1 with no valid that cycle, timeout pulses and the FSM goes to EXPECT_A on the next edge. pa/pb are unchanged.
  - EXPECT_B, valid arriving on the same cycle the timer expires: the valid sample wins and no timeout occurs.
- err_cnt:
  - Increments by 1 per seq_err or timeout event.
  - seq_err and timeout cannot coincide.
  - Saturates at 2^CW-1 with no wrap; cleared only by rst.
- Back-to-back valids every cycle are supported with no bubbles.
- Reset asserted mid-pair discards the pending A; no pair_valid is emitted.

Test Plan:
1. Reset, W=1 → all outputs 0 and state EXPECT_A; release rst with din_valid=0 for 5 cycles → outputs unchanged.
2. Valid (din=1, sel=0) then valid (din=0, sel=1) on consecutive cycles:
   - Cycle after first edge: oa=1, oa_stb=1.
   - Cycle after second edge: ob=0, ob_stb=1, pa=1, pb=0, pair_valid=1.
   - seq_err stays 0.
3. Valid sel=1 first from EXPECT_A → ob updated, seq_err pulse, err_cnt=1, no pair_valid. Then A=1, B=1 → pair_valid, pa=1, pb=1.
4. A=1, then A=0 (sel=0 twice), then B=1 → seq_err once, pair emitted with pa=0, pb=1.
5. A sample then idle, TIMEOUT=16 → timeout pulses exactly 16 cycles after the A strobe, err_cnt increments, no pair_valid. A later B sample gives seq_err, not a pair. Repeat with B arriving on the expiry cycle → pair_valid and no timeout.
6. CW=2, five sel=1 errors → err_cnt reads 1, 2, 3, 3, 3. Assert rst mid-pair → err_cnt=0 and no pair_valid.
